serial_packet_demux: RTL and testbench

Parametrised serial packet demultiplexer for the MSSD datapath. It watches a bit-strobed serial line for a `10` start pattern and captures a header of channel index plus length. It then steers `length × UNIT_BITS` payload bits onto the selected output channel, with per-channel valid strobes and an end-of-packet pulse. It generalises the fixed 4-channel / 4-bit-length / ×8 receiver to any power-of-two channel count, length width and unit size, and adds bit-strobe stalling, abort and zero-length handling.

---
 rtl/serial_demux_pkg.sv | 11 +
 rtl/serial_header_shift.sv | 36 +++
 rtl/serial_packet_demux.sv | 133 +++++++++++++
 tb/tb_serial_packet_demux.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_demux_pkg.sv
// rtl/serial_demux_pkg.sv - shared types for the serial packet demultiplexer
package serial_demux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SYNC    = 2'd1,
        ST_HEADER  = 2'd2,
        ST_PAYLOAD = 2'd3
    } demux_state_t;

endpackage

// File: rtl/serial_header_shift.sv
// rtl/serial_header_shift.sv - sentinel-terminated header shift register
module serial_header_shift #(
    parameter int HDR_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             clear,
    input  logic             ser_in,
    output logic [HDR_W-1:0] hdr,
    output logic             full
);

    // A single 1 at the MSB marks an empty register; once it has walked down
    // to bit 0, the bit being shifted in now is the last header bit.
    localparam logic [HDR_W-1:0] SENTINEL = HDR_W'(1) << (HDR_W - 1);

    logic [HDR_W-1:0] hdr_q;

    // Shift new bits in at the MSB; clear (or reset) re-arms the sentinel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hdr_q <= SENTINEL;
        end else if (clear) begin
            hdr_q <= SENTINEL;
        end else if (shift_en) begin
            hdr_q <= {ser_in, hdr_q[HDR_W-1:1]};
        end
    end

    // The completed header includes the bit currently on the wire, so the
    // top can latch it on the same edge that consumes the final bit.
    assign hdr  = {ser_in, hdr_q[HDR_W-1:1]};
    assign full = shift_en & hdr_q[0];

endmodule

// File: rtl/serial_packet_demux.sv
// rtl/serial_packet_demux.sv - serial packet receiver steering payload to per-channel outputs
module serial_packet_demux
    import serial_demux_pkg::*;
#(
    parameter  int NUM_CH    = 4,
    parameter  int LEN_W     = 4,
    parameter  int UNIT_BITS = 8,
    localparam int CH_W      = $clog2(NUM_CH),
    localparam int HDR_W     = CH_W + LEN_W,
    localparam int CNT_W     = LEN_W + $clog2(UNIT_BITS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ser_in,
    input  logic              ser_en,
    input  logic              abort,
    output logic [NUM_CH-1:0] ch_data,
    output logic [NUM_CH-1:0] ch_valid,
    output logic [CH_W-1:0]   cur_ch,
    output logic [CNT_W-1:0]  remaining,
    output logic              busy,
    output logic              done
);

    localparam int UNIT_LOG = $clog2(UNIT_BITS);

    demux_state_t      state_q, state_d;
    logic [NUM_CH-1:0] ch_data_q, ch_data_d;
    logic [NUM_CH-1:0] ch_valid_q, ch_valid_d;
    logic [CH_W-1:0]   cur_ch_q, cur_ch_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              hdr_shift;
    logic              hdr_clear;
    logic [HDR_W-1:0]  hdr;
    logic              hdr_full;
    logic [LEN_W-1:0]  hdr_len;

    assign hdr_shift = ser_en && !abort && (state_q == ST_HEADER);
    assign hdr_clear = abort || hdr_full;
    assign hdr_len   = hdr[HDR_W-1:CH_W];

    serial_header_shift #(
        .HDR_W (HDR_W)
    ) u_hdr (
        .clk      (clk),
        .rst      (rst),
        .shift_en (hdr_shift),
        .clear    (hdr_clear),
        .ser_in   (ser_in),
        .hdr      (hdr),
        .full     (hdr_full)
    );

    // Next-state, counter and output steering; everything holds unless a bit is strobed.
    always_comb begin
        state_d     = state_q;
        cur_ch_d    = cur_ch_q;
        remaining_d = remaining_q;
        ch_data_d   = '0;
        ch_valid_d  = '0;
        done_d      = 1'b0;

        if (abort) begin
            state_d     = ST_IDLE;
            remaining_d = '0;
        end else if (ser_en) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (ser_in) state_d = ST_SYNC;
                end
                ST_SYNC: begin
                    if (!ser_in) state_d = ST_HEADER;
                end
                ST_HEADER: begin
                    if (hdr_full) begin
                        cur_ch_d = hdr[CH_W-1:0];
                        if (hdr_len == '0) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            remaining_d = CNT_W'(hdr_len) << UNIT_LOG;
                            state_d     = ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    ch_valid_d  = NUM_CH'(1) << cur_ch_q;
                    ch_data_d   = ser_in ? (NUM_CH'(1) << cur_ch_q) : '0;
                    remaining_d = remaining_q - CNT_W'(1);
                    if (remaining_q == CNT_W'(1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        busy_d = (state_d == ST_HEADER) || (state_d == ST_PAYLOAD);
    end

    // State and registered outputs; reset clears them immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cur_ch_q    <= '0;
            remaining_q <= '0;
            ch_data_q   <= '0;
            ch_valid_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_ch_q    <= cur_ch_d;
            remaining_q <= remaining_d;
            ch_data_q   <= ch_data_d;
            ch_valid_q  <= ch_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign ch_data   = ch_data_q;
    assign ch_valid  = ch_valid_q;
    assign cur_ch    = cur_ch_q;
    assign remaining = remaining_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_serial_packet_demux.sv
// tb/tb_serial_packet_demux.sv - directed bench for serial_packet_demux
module tb_serial_packet_demux;

    logic       clk = 1'b0;
    logic       rst;
    logic       ser_in, ser_en, abort;
    logic [3:0] ch_data, ch_valid;
    logic [1:0] cur_ch;
    logic [6:0] remaining;
    logic       busy, done;

    logic       ser_in2, ser_en2, abort2;
    logic [7:0] ch_data2, ch_valid2;
    logic [2:0] cur_ch2;
    logic [4:0] remaining2;
    logic       busy2, done2;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    serial_packet_demux dut (
        .clk(clk), .rst(rst), .ser_in(ser_in), .ser_en(ser_en), .abort(abort),
        .ch_data(ch_data), .ch_valid(ch_valid), .cur_ch(cur_ch),
        .remaining(remaining), .busy(busy), .done(done)
    );

    serial_packet_demux #(.NUM_CH(8), .LEN_W(3), .UNIT_BITS(4)) dut8 (
        .clk(clk), .rst(rst), .ser_in(ser_in2), .ser_en(ser_en2), .abort(abort2),
        .ch_data(ch_data2), .ch_valid(ch_valid2), .cur_ch(cur_ch2),
        .remaining(remaining2), .busy(busy2), .done(done2)
    );

    task automatic send_bit(input logic b, input logic en);
        @(negedge clk);
        ser_in = b;
        ser_en = en;
        @(posedge clk);
        #1;
    endtask

    task automatic send_header(input logic [1:0] ch, input logic [3:0] len);
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b1);
        for (int i = 0; i < 2; i++) send_bit(ch[i], 1'b1);
        for (int i = 0; i < 4; i++) send_bit(len[i], 1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b1; ser_in = 1'b0; ser_en = 1'b0; abort = 1'b0;
        ser_in2 = 1'b0; ser_en2 = 1'b0; abort2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({ch_data, ch_valid, cur_ch, remaining, busy, done} !== 19'd0) begin
            miscompares++;
            $display("FAIL reset_outputs got %h want 0", {ch_data, ch_valid, cur_ch, remaining, busy, done});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_nominal();
        logic [7:0] pay = 8'b10110010;
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b1);
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL nom_busy_rise got %b want 1", busy); end
        for (int i = 0; i < 2; i++) send_bit(i == 1, 1'b1);
        for (int i = 0; i < 4; i++) send_bit(i == 0, 1'b1);
        vectors++;
        if (remaining !== 7'd8 || cur_ch !== 2'd2 || ch_valid !== 4'd0) begin
            miscompares++;
            $display("FAIL nom_hdr rem %0d ch %0d vld %b want 8 2 0000", remaining, cur_ch, ch_valid);
        end
        for (int i = 0; i < 8; i++) begin
            send_bit(pay[7-i], 1'b1);
            vectors++;
            if (ch_valid !== 4'b0100 || ch_data !== {1'b0, pay[7-i], 2'b00} || remaining !== 7'(7 - i)
                || done !== (i == 7) || busy !== (i != 7)) begin
                miscompares++;
                $display("FAIL nom_bit%0d vld %b dat %b rem %0d done %b busy %b", i, ch_valid, ch_data, remaining, done, busy);
            end
        end
        send_bit(1'b0, 1'b0);
        vectors++;
        if (done !== 1'b0 || ch_valid !== 4'd0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL nom_after done %b vld %b busy %b want 0 0000 0", done, ch_valid, busy);
        end
    endtask

    task automatic test_zero_length();
        int bad = 0;
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            send_bit(i < 2, 1'b1);
            if (ch_valid !== 4'd0 || done !== 1'b0) bad++;
        end
        send_bit(1'b0, 1'b1);
        vectors++;
        if (done !== 1'b1 || ch_valid !== 4'd0 || busy !== 1'b0 || cur_ch !== 2'd3 || bad != 0) begin
            miscompares++;
            $display("FAIL zero_len done %b vld %b busy %b ch %0d early %0d", done, ch_valid, busy, cur_ch, bad);
        end
        send_bit(1'b0, 1'b1);
        vectors++;
        if (done !== 1'b0 || ch_valid !== 4'd0) begin
            miscompares++;
            $display("FAIL zero_len_pulse done %b vld %b want 0 0000", done, ch_valid);
        end
    endtask

    task automatic test_stall();
        int nvalid = 0;
        int k = 0;
        send_header(2'd2, 4'd1);
        for (int i = 0; i < 16; i++) begin
            logic en;
            en = (i % 2 == 0);
            send_bit(i[1], en);
            if (en) k++;
            if (ch_valid == 4'b0100) nvalid++;
            vectors++;
            if (remaining !== 7'(8 - k) || ch_valid !== (en ? 4'b0100 : 4'b0000) || done !== (en && k == 8)) begin
                miscompares++;
                $display("FAIL stall_cyc%0d rem %0d vld %b done %b want rem %0d", i, remaining, ch_valid, done, 8 - k);
            end
        end
        vectors++;
        if (nvalid != 8) begin miscompares++; $display("FAIL stall_count got %0d want 8", nvalid); end
    endtask

    task automatic test_max_length();
        int bad = 0;
        send_header(2'd1, 4'd15);
        vectors++;
        if (remaining !== 7'd120 || cur_ch !== 2'd1) begin
            miscompares++;
            $display("FAIL max_start rem %0d ch %0d want 120 1", remaining, cur_ch);
        end
        for (int i = 0; i < 120; i++) begin
            logic b;
            b = i[0] ^ i[2];
            send_bit(b, 1'b1);
            if (ch_valid !== 4'b0010 || ch_data !== {2'b00, b, 1'b0} || done !== (i == 119)) bad++;
        end
        vectors++;
        if (bad != 0 || remaining !== 7'd0) begin
            miscompares++;
            $display("FAIL max_payload bad %0d rem %0d want 0 0", bad, remaining);
        end
        bad = 0;
        send_header(2'd0, 4'd1);
        for (int i = 0; i < 8; i++) begin
            send_bit(1'b1, 1'b1);
            if (ch_valid !== 4'b0001 || ch_data !== 4'b0001 || done !== (i == 7)) bad++;
        end
        vectors++;
        if (bad != 0) begin miscompares++; $display("FAIL max_back_to_back bad %0d want 0", bad); end
    endtask

    task automatic test_abort_reset();
        int bad = 0;
        send_header(2'd2, 4'd1);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b1);
        @(negedge clk);
        abort = 1'b1; ser_en = 1'b1; ser_in = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || ch_valid !== 4'd0 || remaining !== 7'd0) begin
            miscompares++;
            $display("FAIL abort busy %b done %b vld %b rem %0d want 0 0 0000 0", busy, done, ch_valid, remaining);
        end
        @(negedge clk);
        abort = 1'b0;
        send_bit(1'b0, 1'b0);
        send_header(2'd3, 4'd1);
        for (int i = 0; i < 8; i++) begin
            send_bit(1'b0, 1'b1);
            if (ch_valid !== 4'b1000 || done !== (i == 7)) bad++;
        end
        vectors++;
        if (bad != 0) begin miscompares++; $display("FAIL abort_next bad %0d want 0", bad); end

        send_header(2'd1, 4'd1);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if ({ch_data, ch_valid, cur_ch, remaining, busy, done} !== 19'd0) begin
            miscompares++;
            $display("FAIL async_reset got %h want 0", {ch_data, ch_valid, cur_ch, remaining, busy, done});
        end
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        send_header(2'd2, 4'd1);
        for (int i = 0; i < 8; i++) begin
            send_bit(1'b1, 1'b1);
            if (ch_valid !== 4'b0100 || done !== (i == 7)) bad++;
        end
        vectors++;
        if (bad != 0) begin miscompares++; $display("FAIL reset_next bad %0d want 0", bad); end
    endtask

    task automatic test_param_instance();
        logic [7:0] hbits = 8'b00_010_101;
        int nvalid = 0;
        int bad = 0;
        for (int i = 0; i < 8; i++) begin
            logic b;
            b = (i == 0) ? 1'b1 : (i == 1) ? 1'b0 : hbits[i-2];
            @(negedge clk);
            ser_in2 = b; ser_en2 = 1'b1;
            @(posedge clk);
            #1;
        end
        vectors++;
        if (remaining2 !== 5'd8 || cur_ch2 !== 3'd5 || busy2 !== 1'b1) begin
            miscompares++;
            $display("FAIL p8_hdr rem %0d ch %0d busy %b want 8 5 1", remaining2, cur_ch2, busy2);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            ser_in2 = i[0]; ser_en2 = 1'b1;
            @(posedge clk);
            #1;
            if (ch_valid2 == 8'b0010_0000) nvalid++;
            if (ch_data2 !== {2'b00, i[0], 5'b0} || done2 !== (i == 7)) bad++;
        end
        vectors++;
        if (nvalid != 8 || bad != 0) begin
            miscompares++;
            $display("FAIL p8_payload valid %0d bad %0d want 8 0", nvalid, bad);
        end
        @(negedge clk);
        ser_en2 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_zero_length();
        test_stall();
        test_max_length();
        test_abort_reset();
        test_param_instance();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1);
    end

endmodule
